// File: rtl/adder_pipe.sv
// Two-stage pipelined integer adder: add/shNadd/sub, add.uw family, sext/zext,
// min/max and W-variants, with valid/ready backpressure, tag passthrough and flush.
module adder_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [4:0]       op_i,
    input  logic             word_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam logic [XLEN-1:0] LO32_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]  s1_opa_q,   s1_opa_d;
    logic [XLEN-1:0]  s1_opb_q,   s1_opb_d;
    logic [XLEN-1:0]  s1_sum_q,   s1_sum_d;
    logic             s1_lt_q,    s1_lt_d;
    logic [4:0]       s1_op_q,    s1_op_d;
    logic             s1_word_q,  s1_word_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    // Stage 2 state
    logic             s2_valid_q,  s2_valid_d;
    logic [XLEN-1:0]  s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q,    s2_tag_d;

    logic             advance;
    logic             accept;
    logic             move;

    always_comb begin
        advance    = !s2_valid_q || out_ready_i;
        in_ready_o = advance || !s1_valid_q;
        accept     = in_valid_i && in_ready_o && !flush_i;
        move       = advance && s1_valid_q;
    end

    // Operand preparation: only the arithmetic groups shift; only sub complements.
    logic [1:0]      ss_eff;
    logic            is_sub;
    logic            cmp_unsigned;
    logic [XLEN-1:0] a_src;
    logic [XLEN-1:0] a_sh;
    logic [XLEN-1:0] b_op;
    logic            lt;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        ss_eff       = 2'd0;
        is_sub       = (op_i[4:2] == 3'b001);
        cmp_unsigned = op_i[0];
        a_src        = (op_i[4:2] == 3'b010) ? (a_i & LO32_MASK) : a_i;
        if (op_i[4:3] == 2'b00 || op_i[4:2] == 3'b010) begin
            ss_eff = op_i[1:0];
        end
        a_sh = a_src << ss_eff;
        b_op = is_sub ? ~b_i : b_i;
        // Less-than is the borrow of an XLEN+1 subtraction on sign/zero-extended operands.
        lt = 1'(({(!cmp_unsigned && a_i[XLEN-1]), a_i}
                - {(!cmp_unsigned && b_i[XLEN-1]), b_i}) >> XLEN);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_opa_d   = s1_opa_q;
        s1_opb_d   = s1_opb_q;
        s1_sum_d   = s1_sum_q;
        s1_lt_d    = s1_lt_q;
        s1_op_d    = s1_op_q;
        s1_word_d  = s1_word_q;
        s1_tag_d   = s1_tag_q;

        if (flush_i) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        if (accept) begin
            s1_opa_d  = a_sh;
            s1_opb_d  = b_op;
            s1_sum_d  = a_sh + b_op + XLEN'(is_sub);
            s1_lt_d   = lt;
            s1_op_d   = op_i;
            s1_word_d = word_i;
            s1_tag_d  = tag_i;
        end
    end

    logic [XLEN-1:0] sel_result;

    always_comb begin
        sel_result = '0;
        casez (s1_op_q)
            5'b000??, 5'b001??, 5'b010??: sel_result = s1_sum_q;
            5'b01100:                     sel_result = XLEN'($signed(s1_opa_q[7:0]));
            5'b01101:                     sel_result = XLEN'($signed(s1_opa_q[15:0]));
            5'b01110:                     sel_result = XLEN'(s1_opa_q[15:0]);
            5'b10000, 5'b10001:           sel_result = s1_lt_q ? s1_opa_q : s1_opb_q;
            5'b10010, 5'b10011:           sel_result = s1_lt_q ? s1_opb_q : s1_opa_q;
            default:                      sel_result = '0;
        endcase
        // For XLEN=32 this sign-extension is an identity, so word_i is ignored there.
        if (s1_word_q) begin
            sel_result = XLEN'($signed(sel_result[31:0]));
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;

        if (flush_i) begin
            s2_valid_d = 1'b0;
        end else if (advance) begin
            s2_valid_d = s1_valid_q;
        end

        if (move) begin
            s2_result_d = sel_result;
            s2_tag_d    = s1_tag_q;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (cpu_reset_i) begin
            s1_valid_q  <= 1'b0;
            s1_opa_q    <= '0;
            s1_opb_q    <= '0;
            s1_sum_q    <= '0;
            s1_lt_q     <= 1'b0;
            s1_op_q     <= '0;
            s1_word_q   <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_opa_q    <= s1_opa_d;
            s1_opb_q    <= s1_opb_d;
            s1_sum_q    <= s1_sum_d;
            s1_lt_q     <= s1_lt_d;
            s1_op_q     <= s1_op_d;
            s1_word_q   <= s1_word_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    always_comb begin
        out_valid_o = s2_valid_q;
        result_o    = s2_result_q;
        tag_o       = s2_tag_q;
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream;
// a vector table covers the datapath, hand sequences cover backpressure, flush and reset.
module tb_adder_pipe;

    logic        cpu_clock_i;
    logic        cpu_reset_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        out_ready_i;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  op;
    logic        word;
    logic [5:0]  tag;

    logic        in_ready32, out_valid32;
    logic [31:0] res32;
    logic [5:0]  tag32;
    logic        in_ready64, out_valid64;
    logic [63:0] res64;
    logic [5:0]  tag64;

    int n_checks = 0;
    int n_fail   = 0;

    adder_pipe #(.XLEN(32), .TAG_W(6)) u32 (
        .cpu_clock_i (cpu_clock_i),
        .cpu_reset_i (cpu_reset_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready32),
        .a_i         (a[31:0]),
        .b_i         (b[31:0]),
        .op_i        (op),
        .word_i      (word),
        .tag_i       (tag),
        .out_valid_o (out_valid32),
        .out_ready_i (out_ready_i),
        .result_o    (res32),
        .tag_o       (tag32)
    );

    adder_pipe #(.XLEN(64), .TAG_W(6)) u64 (
        .cpu_clock_i (cpu_clock_i),
        .cpu_reset_i (cpu_reset_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready64),
        .a_i         (a),
        .b_i         (b),
        .op_i        (op),
        .word_i      (word),
        .tag_i       (tag),
        .out_valid_o (out_valid64),
        .out_ready_i (out_ready_i),
        .result_o    (res64),
        .tag_o       (tag64)
    );

    initial cpu_clock_i = 1'b0;
    always #5 cpu_clock_i = ~cpu_clock_i;

    typedef struct packed {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        word;
        logic        is64;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [4:0] o, input logic [63:0] aa, input logic [63:0] bb,
                                input logic w, input logic x64, input logic [63:0] e);
        vec_t v;
        v.op = o; v.a = aa; v.b = bb; v.word = w; v.is64 = x64; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clock_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] o, input logic [63:0] aa,
                         input logic [63:0] bb, input logic w, input logic [5:0] t);
        in_valid_i = v; op = o; a = aa; b = bb; word = w; tag = t;
    endtask

    task automatic check_out32(input string name, input logic v, input logic [31:0] r,
                               input logic [5:0] t);
        check({name, "_valid"}, 64'(out_valid32), 64'(v));
        check({name, "_result"}, 64'(res32), 64'(r));
        check({name, "_tag"}, 64'(tag32), 64'(t));
    endtask

    initial begin
        int nv;

        cpu_reset_i = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 6'd0);
        repeat (2) step();
        check_out32("reset32", 1'b0, 32'd0, 6'd0);
        check("reset32_in_ready", 64'(in_ready32), 64'd1);
        check("reset64_valid", 64'(out_valid64), 64'd0);
        check("reset64_result", res64, 64'd0);
        check("reset64_in_ready", 64'(in_ready64), 64'd1);
        cpu_reset_i = 1'b0;
        step();

        // XLEN=32 vectors
        add(5'b00011, 64'h10,         64'h5,  1'b0, 1'b0, 64'h85);
        add(5'b00100, 64'h3,          64'h5,  1'b0, 1'b0, 64'hFFFF_FFFE);
        add(5'b01100, 64'h80,         64'h0,  1'b0, 1'b0, 64'hFFFF_FF80);
        add(5'b10000, 64'hFFFF_FFFF,  64'h1,  1'b0, 1'b0, 64'hFFFF_FFFF);
        add(5'b10001, 64'hFFFF_FFFF,  64'h1,  1'b0, 1'b0, 64'h1);
        add(5'b10010, 64'hFFFF_FFFF,  64'h1,  1'b0, 1'b0, 64'h1);
        add(5'b10011, 64'hFFFF_FFFF,  64'h1,  1'b0, 1'b0, 64'hFFFF_FFFF);
        add(5'b10000, 64'h7,          64'h7,  1'b0, 1'b0, 64'h7);
        add(5'b10001, 64'h7,          64'h7,  1'b0, 1'b0, 64'h7);
        add(5'b10010, 64'h7,          64'h7,  1'b0, 1'b0, 64'h7);
        add(5'b10011, 64'h7,          64'h7,  1'b0, 1'b0, 64'h7);
        add(5'b01101, 64'h0000_8001,  64'h0,  1'b0, 1'b0, 64'hFFFF_8001);
        add(5'b01110, 64'hABCD_1234,  64'h0,  1'b0, 1'b0, 64'h1234);
        add(5'b01111, 64'h5,          64'h5,  1'b0, 1'b0, 64'h0);
        add(5'b10100, 64'h5,          64'h5,  1'b0, 1'b0, 64'h0);
        add(5'b11111, 64'h5,          64'h5,  1'b0, 1'b0, 64'h0);
        add(5'b00011, 64'hF000_0001,  64'h0,  1'b0, 1'b0, 64'h8000_0008);
        add(5'b00101, 64'h10,         64'h21, 1'b0, 1'b0, 64'hFFFF_FFFF);
        add(5'b01010, 64'h3,          64'h1,  1'b0, 1'b0, 64'hD);
        // XLEN=64 vectors
        add(5'b01001, 64'hFFFF_FFFF_8000_0000, 64'h0, 1'b0, 1'b1, 64'h1_0000_0000);
        add(5'b00000, 64'h7FFF_FFFF, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000);
        add(5'b10000, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h8000_0000_0000_0000);
        add(5'b10011, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h8000_0000_0000_0000);
        add(5'b10010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF);
        add(5'b00100, 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        add(5'b00000, 64'h1_0000_0005, 64'h0, 1'b1, 1'b1, 64'h5);
        add(5'b10001, 64'h8000_0000, 64'h1_0000_0000, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000);

        // Back-to-back: vector s is offered in step s and leaves S2 after the next edge.
        nv = vecs.size();
        out_ready_i = 1'b1;
        for (int s = 0; s <= nv; s++) begin
            if (s < nv) begin
                drive(1'b1, vecs[s].op, vecs[s].a, vecs[s].b, vecs[s].word, 6'(s));
            end else begin
                in_valid_i = 1'b0;
            end
            step();
            if (s == 0) begin
                check("first_latency_valid", 64'(out_valid32), 64'd0);
            end else begin
                vec_t v;
                v = vecs[s-1];
                check($sformatf("vec%0d_valid", s-1),
                      64'(v.is64 ? out_valid64 : out_valid32), 64'd1);
                check($sformatf("vec%0d_tag", s-1), 64'(v.is64 ? tag64 : tag32), 64'(s-1));
                check($sformatf("vec%0d_result", s-1),
                      v.is64 ? res64 : {32'd0, res32}, v.exp);
            end
        end
        step();
        check("drain_valid", 64'(out_valid32), 64'd0);

        // Backpressure: three ops with the consumer stalled.
        out_ready_i = 1'b0;
        drive(1'b1, 5'b00000, 64'd1, 64'd10, 1'b0, 6'd20);
        #1 check("bp_ready_first", 64'(in_ready32), 64'd1);
        step();
        drive(1'b1, 5'b00000, 64'd2, 64'd20, 1'b0, 6'd21);
        check("bp_ready_second", 64'(in_ready32), 64'd1);
        step();
        drive(1'b1, 5'b00000, 64'd3, 64'd30, 1'b0, 6'd22);
        check("bp_ready_full", 64'(in_ready32), 64'd0);
        check_out32("bp_hold0", 1'b1, 32'd11, 6'd20);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("bp_ready_stall%0d", i), 64'(in_ready32), 64'd0);
            check_out32($sformatf("bp_hold%0d", i), 1'b1, 32'd11, 6'd20);
        end
        out_ready_i = 1'b1;
        #1 check("bp_ready_release", 64'(in_ready32), 64'd1);
        step();
        in_valid_i = 1'b0;
        check_out32("bp_out_second", 1'b1, 32'd22, 6'd21);
        step();
        check_out32("bp_out_third", 1'b1, 32'd33, 6'd22);
        step();
        check("bp_empty", 64'(out_valid32), 64'd0);

        // Flush with a full pipe; T3 arrives together with flush_i.
        out_ready_i = 1'b0;
        drive(1'b1, 5'b00000, 64'd1, 64'd1, 1'b0, 6'd31);
        step();
        drive(1'b1, 5'b00000, 64'd2, 64'd2, 1'b0, 6'd32);
        step();
        drive(1'b1, 5'b00000, 64'd3, 64'd3, 1'b0, 6'd33);
        flush_i = 1'b1;
        #1 check("flush_ready_unaffected", 64'(in_ready32), 64'd0);
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check("flush_valid32", 64'(out_valid32), 64'd0);
        check("flush_valid64", 64'(out_valid64), 64'd0);
        check("flush_ready_after", 64'(in_ready32), 64'd1);
        drive(1'b1, 5'b00001, 64'd5, 64'd1, 1'b0, 6'd34);
        out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        check("post_flush_not_yet", 64'(out_valid32), 64'd0);
        step();
        check_out32("post_flush_op", 1'b1, 32'd11, 6'd34);
        step();
        check("post_flush_nothing_else", 64'(out_valid32), 64'd0);

        // Op offered during flush into an empty pipe must be dropped.
        drive(1'b1, 5'b00000, 64'd9, 64'd9, 1'b0, 6'd35);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        step();
        check("flush_drop_offered", 64'(out_valid32), 64'd0);
        step();
        check("flush_drop_offered_late", 64'(out_valid32), 64'd0);

        // Reset with both stages occupied.
        out_ready_i = 1'b0;
        drive(1'b1, 5'b00000, 64'd4, 64'd4, 1'b0, 6'd40);
        step();
        drive(1'b1, 5'b00000, 64'd6, 64'd6, 1'b0, 6'd41);
        step();
        in_valid_i = 1'b0;
        check("pre_reset_full_valid", 64'(out_valid32), 64'd1);
        check("pre_reset_full_ready", 64'(in_ready32), 64'd0);
        cpu_reset_i = 1'b1;
        step();
        cpu_reset_i = 1'b0;
        check_out32("mid_reset", 1'b0, 32'd0, 6'd0);
        check("mid_reset_ready", 64'(in_ready32), 64'd1);
        out_ready_i = 1'b1;
        step();
        check("mid_reset_s1_cleared", 64'(out_valid32), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
